// File: rtl/rr_arbiter_8to3.sv
// Round-robin arbiter sharing one resource among 8 requesters, presenting each
// grant as a one-hot vector plus its 8-to-3 encoded index, with a hold-time limit.
module rr_arbiter_8to3 #(
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_req,
   input  logic       i_release,
   output logic [7:0] o_grant,
   output logic [2:0] o_grant_idx,
   output logic       o_grant_valid,
   output logic       o_timeout
);

   localparam int unsigned N_REQ = 8;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t           r_state;
   logic [N_REQ-1:0] r_grant;
   logic [IDX_W-1:0] r_grant_idx;
   logic [IDX_W-1:0] r_last_idx;
   logic [CNT_W-1:0] r_hold_cnt;
   logic             r_grant_valid;
   logic             r_timeout;

   logic [N_REQ-1:0] w_win_oh;
   logic [IDX_W-1:0] w_win_idx;
   logic [IDX_W-1:0] w_cand;
   logic             w_found;

   // Classic OR-plane 8-to-3 encoder for a one-hot (or zero) vector.
   function automatic logic [IDX_W-1:0] enc8to3(input logic [N_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx[0] = oh[1] | oh[3] | oh[5] | oh[7];
      idx[1] = oh[2] | oh[3] | oh[6] | oh[7];
      idx[2] = oh[4] | oh[5] | oh[6] | oh[7];
      return idx;
   endfunction

   // Scan from the requester after the last one served, wrapping; last served ranks lowest.
   always_comb begin
      w_win_oh = '0;
      w_found  = 1'b0;
      w_cand   = '0;
      for (int k = 1; k <= int'(N_REQ); k++) begin
         w_cand = r_last_idx + IDX_W'(k);
         if (!w_found && i_req[w_cand]) begin
            w_win_oh = N_REQ'(1) << w_cand;
            w_found  = 1'b1;
         end
      end
   end

   assign w_win_idx = enc8to3(w_win_oh);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_grant       <= '0;
         r_grant_idx   <= '0;
         r_grant_valid <= 1'b0;
         r_last_idx    <= IDX_W'(N_REQ - 1);
         r_hold_cnt    <= '0;
         r_timeout     <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant       <= w_win_oh;
                  r_grant_idx   <= w_win_idx;
                  r_grant_valid <= 1'b1;
                  r_hold_cnt    <= '0;
                  r_state       <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // Release or a dropped request wins over an expiring hold counter.
               if (i_release || !i_req[r_grant_idx]) begin
                  r_grant       <= '0;
                  r_grant_valid <= 1'b0;
                  r_last_idx    <= r_grant_idx;
                  r_state       <= ST_IDLE;
               end else if (r_hold_cnt == HOLD_LAST) begin
                  r_grant       <= '0;
                  r_grant_valid <= 1'b0;
                  r_last_idx    <= r_grant_idx;
                  r_timeout     <= 1'b1;
                  r_state       <= ST_IDLE;
               end else begin
                  r_hold_cnt <= r_hold_cnt + CNT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_grant       = r_grant;
   assign o_grant_idx   = r_grant_idx;
   assign o_grant_valid = r_grant_valid;
   assign o_timeout     = r_timeout;

endmodule
